// File: rtl/ariane_pkg.sv
// ariane_pkg: core-wide types, including the branch history table update format
// and the entry layout used by the BHT update buffer.
package ariane_pkg;
    localparam int BHT_UPD_BUF_DEPTH = 4;

    typedef struct packed {
        logic                    valid;
        logic [riscv::VLEN-1:0]  pc;
        logic                    taken;
    } bht_update_t;

    typedef struct packed {
        logic [riscv::VLEN-1:0]  pc;
        logic                    taken;
    } bht_upd_entry_t;
endpackage

// File: rtl/riscv.sv
// riscv: architectural constants shared across the core.
package riscv;
    localparam int unsigned VLEN = 64;
endpackage

// File: rtl/bht_upd_fifo.sv
// bht_upd_fifo: pointer/count FIFO with a combinational head read, a tail read
// port and an in-place tail overwrite.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   flush_i       : empty the FIFO (pointers and count to 0), highest priority
//   push_i        : write wdata_i at the write pointer
//   ovr_i         : overwrite the most recently written entry (ignored on push)
//   pop_i         : advance the read pointer
//   head_o/tail_o : oldest / newest entry
//   count_o       : number of valid entries
module bht_upd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic                   ovr_i,
    input  logic                   pop_i,
    input  logic [W-1:0]           wdata_i,
    output logic [W-1:0]           head_o,
    output logic [W-1:0]           tail_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] rd_ptr_q, wr_ptr_q, tail_idx;
    logic [AW:0]   count_q;
    logic [W-1:0]  mem_q [DEPTH];

    // Pointers wrap by natural overflow since DEPTH is a power of two.
    assign tail_idx = wr_ptr_q - AW'(1);
    assign head_o   = mem_q[rd_ptr_q];
    assign tail_o   = mem_q[tail_idx];
    assign count_o  = count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end else if (ovr_i) begin
                mem_q[tail_idx] <= wdata_i;
            end
            if (pop_i) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end
endmodule

// File: rtl/bht_update_buffer.sv
// bht_update_buffer: buffers resolved conditional branches ahead of the BHT
// update port, coalescing repeated updates to the same PC and counting drops.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   flush_i        : discard all buffered updates
//   debug_mode_i   : suppress enqueue and drain
//   hold_i         : table cannot take an update this cycle (drain only)
//   res_*_i        : branch resolution from execute
//   bht_update_o   : {valid, pc, taken} to the table, one per cycle
//   occupancy_o    : buffered entries; full_o when equal to DEPTH
//   drop_cnt_o     : saturating count of updates lost to overflow
module bht_update_buffer
    import ariane_pkg::*;
#(
    parameter int DEPTH     = BHT_UPD_BUF_DEPTH,
    parameter int CNT_WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     debug_mode_i,
    input  logic                     hold_i,
    input  logic                     res_valid_i,
    input  logic                     res_is_cond_i,
    input  logic [riscv::VLEN-1:0]   res_pc_i,
    input  logic                     res_taken_i,
    output bht_update_t              bht_update_o,
    output logic [$clog2(DEPTH):0]   occupancy_o,
    output logic                     full_o,
    output logic [CNT_WIDTH-1:0]     drop_cnt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    bht_upd_entry_t head, tail, wdata;
    logic [AW:0]    count;
    logic           req, pop, coalesce, push, drop;
    logic [CNT_WIDTH-1:0] drop_cnt_q;

    // Flush suppresses every action in its cycle, so it gates the request here.
    assign req      = res_valid_i && res_is_cond_i && !debug_mode_i && !flush_i;
    assign pop      = (count != '0) && !hold_i && !debug_mode_i && !flush_i;
    // A matching sole entry leaving this cycle cannot absorb the update.
    assign coalesce = req && (count != '0) && (tail.pc == res_pc_i) &&
                      !(pop && count == (AW+1)'(1));
    assign push     = req && !coalesce && ((count < FULL) || pop);
    assign drop     = req && !coalesce && (count == FULL) && !pop;
    assign wdata    = '{pc: res_pc_i, taken: res_taken_i};

    bht_upd_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(bht_upd_entry_t))
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (push),
        .ovr_i   (coalesce),
        .pop_i   (pop),
        .wdata_i (wdata),
        .head_o  (head),
        .tail_o  (tail),
        .count_o (count)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) drop_cnt_q <= '0;
        else if (drop && !(&drop_cnt_q)) drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(1);
    end

    assign bht_update_o = '{valid: pop, pc: head.pc, taken: head.taken};
    assign occupancy_o  = count;
    assign full_o       = (count == FULL);
    assign drop_cnt_o   = drop_cnt_q;
endmodule

// File: tb/tb_bht_update_buffer.sv
// tb_bht_update_buffer: directed self-checking bench for bht_update_buffer.
module tb_bht_update_buffer;
    import ariane_pkg::*;

    logic                   clk_i = 1'b0;
    logic                   rst_ni = 1'b0;
    logic                   flush_i = 1'b0;
    logic                   debug_mode_i = 1'b0;
    logic                   hold_i = 1'b0;
    logic                   res_valid_i = 1'b0;
    logic                   res_is_cond_i = 1'b0;
    logic [riscv::VLEN-1:0] res_pc_i = '0;
    logic                   res_taken_i = 1'b0;
    bht_update_t            bht_update_o;
    logic [2:0]             occupancy_o;
    logic                   full_o;
    logic [15:0]            drop_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    bht_update_buffer #(.DEPTH(4), .CNT_WIDTH(16)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .debug_mode_i  (debug_mode_i),
        .hold_i        (hold_i),
        .res_valid_i   (res_valid_i),
        .res_is_cond_i (res_is_cond_i),
        .res_pc_i      (res_pc_i),
        .res_taken_i   (res_taken_i),
        .bht_update_o  (bht_update_o),
        .occupancy_o   (occupancy_o),
        .full_o        (full_o),
        .drop_cnt_o    (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic res(input logic v, input logic c, input logic [63:0] pc, input logic t);
        res_valid_i   = v;
        res_is_cond_i = c;
        res_pc_i      = pc;
        res_taken_i   = t;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [63:0] pc, input logic t);
        #1;
        chk({tag, ".valid"}, 64'(bht_update_o.valid), 64'(v));
        if (v) begin
            chk({tag, ".pc"}, bht_update_o.pc, pc);
            chk({tag, ".taken"}, 64'(bht_update_o.taken), 64'(t));
        end
    endtask

    initial begin
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst.upd", 64'(bht_update_o), 64'(0));
        chk("rst.occ", 64'(occupancy_o), 64'd0);
        chk("rst.full", 64'(full_o), 64'd0);
        chk("rst.drop", 64'(drop_cnt_o), 64'd0);
        rst_ni = 1'b1;

        // single update, no same-cycle bypass
        res(1, 1, 64'h1000, 1);
        chk_out("lat.c1", 0, 0, 0);
        tick();
        res(0, 0, 0, 0);
        chk_out("lat.c2", 1, 64'h1000, 1);
        chk("lat.occ2", 64'(occupancy_o), 64'd1);
        tick();
        chk("lat.occ3", 64'(occupancy_o), 64'd0);
        chk_out("lat.c3", 0, 0, 0);

        // fill under hold, overflow drop, ordered drain
        hold_i = 1'b1;
        res(1, 1, 64'h100, 1); tick();
        res(1, 1, 64'h104, 0); tick();
        res(1, 1, 64'h108, 1); tick();
        res(1, 1, 64'h10C, 0); tick();
        chk("fill.full", 64'(full_o), 64'd1);
        chk("fill.occ", 64'(occupancy_o), 64'd4);
        chk("fill.drop0", 64'(drop_cnt_o), 64'd0);
        res(1, 1, 64'h110, 1); tick();
        res(0, 0, 0, 0);
        chk("ovf.drop", 64'(drop_cnt_o), 64'd1);
        chk("ovf.occ", 64'(occupancy_o), 64'd4);
        hold_i = 1'b0;
        chk_out("drain0", 1, 64'h100, 1); tick();
        chk_out("drain1", 1, 64'h104, 0); tick();
        chk_out("drain2", 1, 64'h108, 1); tick();
        chk_out("drain3", 1, 64'h10C, 0); tick();
        chk_out("drain.empty", 0, 0, 0);
        chk("drain.occ", 64'(occupancy_o), 64'd0);

        // coalesce same PC under hold
        hold_i = 1'b1;
        res(1, 1, 64'h200, 0); tick();
        res(1, 1, 64'h200, 1); tick();
        res(0, 0, 0, 0);
        chk("coal.occ", 64'(occupancy_o), 64'd1);
        hold_i = 1'b0;
        chk_out("coal.out", 1, 64'h200, 1); tick();
        chk_out("coal.after", 0, 0, 0);
        chk("coal.occ2", 64'(occupancy_o), 64'd0);

        // sole matching entry popped this cycle: treated as a fresh push
        res(1, 1, 64'h700, 1); tick();
        res(1, 1, 64'h700, 0);
        chk_out("solepop.out", 1, 64'h700, 1); tick();
        res(0, 0, 0, 0);
        chk("solepop.occ", 64'(occupancy_o), 64'd1);
        chk_out("solepop.out2", 1, 64'h700, 0); tick();
        chk("solepop.occ2", 64'(occupancy_o), 64'd0);

        // full buffer with simultaneous pop accepts the push
        hold_i = 1'b1;
        res(1, 1, 64'h300, 1); tick();
        res(1, 1, 64'h304, 0); tick();
        res(1, 1, 64'h308, 1); tick();
        res(1, 1, 64'h30C, 0); tick();
        hold_i = 1'b0;
        res(1, 1, 64'h310, 1);
        chk_out("fullpop.out", 1, 64'h300, 1); tick();
        res(0, 0, 0, 0);
        chk("fullpop.occ", 64'(occupancy_o), 64'd4);
        chk("fullpop.drop", 64'(drop_cnt_o), 64'd1);
        chk_out("fullpop.next", 1, 64'h304, 0); tick();
        chk("flush.pre", 64'(occupancy_o), 64'd3);

        // flush with a concurrent push
        flush_i = 1'b1;
        res(1, 1, 64'h400, 1);
        chk_out("flush.out", 0, 0, 0); tick();
        flush_i = 1'b0;
        res(0, 0, 0, 0);
        chk("flush.occ", 64'(occupancy_o), 64'd0);
        chk("flush.drop", 64'(drop_cnt_o), 64'd1);
        chk_out("flush.out2", 0, 0, 0); tick();
        chk_out("flush.out3", 0, 0, 0);

        // debug suppresses enqueue; non-conditional ignored
        debug_mode_i = 1'b1;
        res(1, 1, 64'h500, 1);
        chk_out("dbg.out", 0, 0, 0); tick();
        chk("dbg.occ", 64'(occupancy_o), 64'd0);
        debug_mode_i = 1'b0;
        res(1, 0, 64'h600, 1); tick();
        res(0, 0, 0, 0);
        chk("ncond.occ", 64'(occupancy_o), 64'd0);
        chk_out("ncond.out", 0, 0, 0);

        // debug suppresses drain and retains contents
        res(1, 1, 64'h900, 1); tick();
        res(0, 0, 0, 0);
        debug_mode_i = 1'b1;
        chk_out("dbgret.out", 0, 0, 0); tick();
        chk("dbgret.occ", 64'(occupancy_o), 64'd1);
        debug_mode_i = 1'b0;
        chk_out("dbgret.exit", 1, 64'h900, 1); tick();

        // asynchronous reset mid-operation
        hold_i = 1'b1;
        res(1, 1, 64'h800, 1); tick();
        res(0, 0, 0, 0);
        chk("arst.pre", 64'(occupancy_o), 64'd1);
        hold_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        chk("arst.occ", 64'(occupancy_o), 64'd0);
        chk("arst.upd", 64'(bht_update_o), 64'(0));
        chk("arst.drop", 64'(drop_cnt_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
